// File: rtl/ys_poly_small_inv3.sv
// Inverse of the mode-3 small-polynomial transform: recovers g from h with
// g[0] = -h[0]*inv3, g[i] = g[i-1] - h[i]*inv3 (mod 2^DW), 8 lanes per beat.
module ys_poly_small_inv3 #(
    parameter int          DW    = 13,
    parameter int          LANES = 4,
    parameter int          NBEAT = 64,
    parameter logic [12:0] INV3  = 13'd2731
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW*LANES-1:0]        din_a,
    input  logic [DW*LANES-1:0]        din_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW*LANES-1:0]        dout_a,
    output logic [DW*LANES-1:0]        dout_b,
    output logic [$clog2(NBEAT)-1:0]   out_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int IW = $clog2(NBEAT);
    localparam int CW = $clog2(NBEAT + 1);
    localparam int NL = 2 * LANES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_cnt_nx;
    logic [DW-1:0] carry;

    logic          s1_valid;
    logic [DW-1:0] s1_q   [NL];
    logic [DW-1:0] h_lane [NL];
    logic [DW-1:0] g_lane [NL];

    logic [DW*LANES-1:0] g_a;
    logic [DW*LANES-1:0] g_b;

    logic stall;
    logic take_in;
    logic take_out;
    logic drained;

    // Handshake: a beat moves on either port only when valid && ready are both
    // high at the clock edge; a stalled output freezes the whole pipeline.
    assign stall    = out_valid && !out_ready;
    assign in_ready = (state == S_RUN) && (in_cnt < CW'(NBEAT)) && !stall;
    assign take_in  = in_valid && in_ready;
    assign take_out = out_valid && out_ready;

    // True when the last outstanding beat leaves this cycle (or already left).
    assign drained  = (in_cnt == CW'(NBEAT)) && !s1_valid && (!out_valid || out_ready);

    // Index the beat entering stage 2 will carry: beats ahead of it have either
    // already left or are leaving in this same cycle.
    assign out_cnt_nx = out_cnt + CW'(take_out);

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            h_lane[j]         = din_a[DW*j +: DW];
            h_lane[j + LANES] = din_b[DW*j +: DW];
        end
    end

    // In-beat prefix: each lane subtracts the running sum of q from the carry.
    always_comb begin
        logic [DW-1:0] acc;
        acc = carry;
        for (int j = 0; j < NL; j++) begin
            acc       = acc - s1_q[j];
            g_lane[j] = acc;
        end
    end

    always_comb begin
        g_a = '0;
        g_b = '0;
        for (int j = 0; j < LANES; j++) begin
            g_a[DW*j +: DW] = g_lane[j];
            g_b[DW*j +: DW] = g_lane[j + LANES];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (drained) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            carry     <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            dout_a    <= '0;
            dout_b    <= '0;
            for (int j = 0; j < NL; j++) begin
                s1_q[j] <= '0;
            end
        end else if (state == S_IDLE && start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            carry   <= '0;
        end else begin
            if (take_in) begin
                in_cnt <= in_cnt + CW'(1);
            end
            if (take_out) begin
                out_cnt <= out_cnt + CW'(1);
            end
            if (!stall) begin
                s1_valid  <= take_in;
                out_valid <= s1_valid;
                if (take_in) begin
                    for (int j = 0; j < NL; j++) begin
                        s1_q[j] <= h_lane[j] * INV3;
                    end
                end
                // Bubbles leave carry and the output word untouched.
                if (s1_valid) begin
                    dout_a  <= g_a;
                    dout_b  <= g_b;
                    carry   <= g_lane[NL-1];
                    out_idx <= out_cnt_nx[IW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_ys_poly_small_inv3.sv
// Bench for ys_poly_small_inv3: polynomial-level reference model with a
// scoreboard queue, randomized data and output backpressure.
module tb_ys_poly_small_inv3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [51:0]  din_a;
    logic [51:0]  din_b;
    logic         out_valid;
    logic         out_ready;
    logic [51:0]  dout_a;
    logic [51:0]  dout_b;
    logic [5:0]   out_idx;
    logic         busy;
    logic         done;

    ys_poly_small_inv3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_a     (din_a),
        .din_b     (din_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_a    (dout_a),
        .dout_b    (dout_b),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state ----------------
    int g_src [512];
    int h_arr [512];
    int g_ref [512];
    int exp_g [512];

    logic [103:0] exp_q [$];
    logic [5:0]   idx_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;
    int stall_used = 0;
    int done_cnt = 0;
    int first_out_cyc = -1;
    int last_xfer_cyc = 0;
    int acc_cyc = -1;

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // g from h by the recurrence g[i] = g[i-1] - h[i]*inv3, g[-1] = 0.
    task automatic model_inverse();
        int acc;
        acc = 0;
        for (int i = 0; i < 512; i++) begin
            acc = (acc - h_arr[i] * 2731) & 8191;
            g_ref[i] = acc;
        end
    endtask

    task automatic model_forward();
        h_arr[0] = (-3 * g_src[0]) & 8191;
        for (int i = 1; i < 512; i++) begin
            h_arr[i] = (3 * (g_src[i-1] - g_src[i])) & 8191;
        end
    endtask

    function automatic logic [103:0] beat_h(input int k);
        logic [103:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) b[13*j +: 13] = 13'(h_arr[8*k + j]);
        return b;
    endfunction

    function automatic logic [103:0] beat_g(input int k);
        logic [103:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) b[13*j +: 13] = 13'(exp_g[8*k + j]);
        return b;
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {dout_b, dout_a}, '0);
                    check("unexpected_beat_valid", 1'b1, 1'b0);
                end else begin
                    check("dout", {dout_b, dout_a}, exp_q.pop_front());
                    check("out_idx", out_idx, idx_q.pop_front());
                end
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_timing", cyc, last_xfer_cyc + 1);
                check("busy_at_done", busy, 1'b0);
            end
        end
    end

    // ---------------- output-ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    if (!stall_used && out_valid && out_idx == 6'd10) begin
                        out_ready = 1'b0;
                        repeat (3) begin
                            @(posedge clk);
                            #1;
                        end
                        out_ready  = 1'b1;
                        stall_used = 1;
                    end
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- input driver ----------------
    task automatic run_poly(input int rmode, input int bub, input int start_mid, input int abort_at);
        int k;
        int bub_left;
        int guard;
        exp_q.delete();
        idx_q.delete();
        for (int b = 0; b < 64; b++) begin
            exp_q.push_back(beat_g(b));
            idx_q.push_back(6'(b));
        end
        ready_mode    = rmode;
        stall_used    = 0;
        done_cnt      = 0;
        first_out_cyc = -1;
        acc_cyc       = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        k        = 0;
        bub_left = bub ? 2 : 0;
        guard    = 0;
        while (k < 64 && guard < 1000 && k != abort_at) begin
            start = (start_mid != 0 && k == 5);
            if (bub != 0 && k == 20 && bub_left > 0) begin
                in_valid = 1'b0;
                bub_left--;
            end else begin
                in_valid       = 1'b1;
                {din_b, din_a} = beat_h(k);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (k == 0) acc_cyc = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        din_a    = '0;
        din_b    = '0;
        if (abort_at < 0) begin
            check("feed_complete", k, 64);
            @(negedge clk);
            check("in_ready_after_64", in_ready, 1'b0);
            guard = 0;
            while (done_cnt == 0 && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            repeat (3) @(negedge clk);
            check("done_once", done_cnt, 1);
            check("all_beats_out", exp_q.size(), 0);
            check("busy_idle", busy, 1'b0);
            check("latency", first_out_cyc - acc_cyc, 2);
            ready_mode = 0;
        end
    endtask

    task automatic new_random_poly();
        int bad;
        for (int i = 0; i < 512; i++) g_src[i] = $urandom_range(0, 8191);
        model_forward();
        model_inverse();
        bad = 0;
        for (int i = 0; i < 512; i++) if (g_ref[i] != g_src[i]) bad++;
        check("model_roundtrip", bad, 0);
        for (int i = 0; i < 512; i++) exp_g[i] = g_src[i];
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        din_a    = '0;
        din_b    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_dout", {dout_b, dout_a}, '0);
        check("rst_out_idx", out_idx, '0);
        check("rst_busy_done", {busy, done}, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single impulse: h = {8189, 3, 0...}
        for (int i = 0; i < 512; i++) h_arr[i] = 0;
        h_arr[0] = 8189;
        h_arr[1] = 3;
        model_inverse();
        check("pin_imp_g0", g_ref[0], 1);
        check("pin_imp_g1", g_ref[1], 0);
        check("pin_imp_g511", g_ref[511], 0);
        for (int i = 0; i < 512; i++) exp_g[i] = g_ref[i];
        run_poly(0, 0, 0, -1);

        // carry chain, with a start pulse during RUN
        h_arr[1] = 0;
        model_inverse();
        check("pin_chain_g7", g_ref[7], 1);
        check("pin_chain_g511", g_ref[511], 1);
        for (int i = 0; i < 512; i++) exp_g[i] = g_ref[i];
        run_poly(0, 0, 1, -1);

        // round-trip, then the same data under backpressure and bubbles
        new_random_poly();
        run_poly(0, 0, 0, -1);
        run_poly(1, 1, 0, -1);
        check("stall_applied", stall_used, 1);

        // abort at beat 30
        new_random_poly();
        run_poly(0, 0, 0, 30);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_dout", {dout_b, dout_a}, '0);
        check("abort_out_idx", out_idx, '0);
        check("abort_busy_done", {busy, done}, 2'b00);
        exp_q.delete();
        idx_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // in_valid in IDLE is not accepted
        in_valid       = 1'b1;
        {din_b, din_a} = beat_h(0);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_output", out_valid, 1'b0);
        in_valid = 1'b0;

        // fresh run after abort, random output backpressure
        new_random_poly();
        run_poly(2, 1, 0, -1);
        new_random_poly();
        run_poly(2, 0, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
